// File: rtl/mem_pkg.sv
// Shared encodings for mem_access_unit: access sizes, FSM states and default memory latency.
package mem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int unsigned MEM_LAT_DEF = 2;

   // The reserved size code is an alias for a full word.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == SZ_RSVD) ? SZ_WORD : sz;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// lane_mux: big-endian byte-lane extract (load) and merge (store) for one 32-bit word.
module lane_mux
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] ext,
   output logic [31:0] merged
);

   logic [4:0]  sh;
   logic [31:0] mask;

   // Offset 0 is the most significant lane, so the shift grows as the offset shrinks.
   always_comb begin
      sh   = 5'd0;
      mask = 32'hFFFF_FFFF;
      case (size)
         SZ_HALF: begin
            sh   = off[1] ? 5'd0 : 5'd16;
            mask = 32'h0000_FFFF;
         end
         SZ_BYTE: begin
            sh   = {~off, 3'b000};
            mask = 32'h0000_00FF;
         end
         default: ;
      endcase
   end

   assign ext    = (word >> sh) & mask;
   assign merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store responder for a fixed-latency big-endian word memory.
// Define MAU_ALIGN_CHECK_EN to flag misaligned accesses instead of force-aligning them.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              MemCtrl,
   input  logic [1:0]        LSCtrl,
   input  logic [1:0]        SSCtrl,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              busy,
   output logic              align_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic [2:0]        state, state_d;
   logic              is_wr;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, word_q;
   logic [3:0]        cnt;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       lane_word, lane_ext, lane_merged;

   always_comb begin
      req_size = norm_size(MemCtrl ? SSCtrl : LSCtrl);
      acc_addr = addr;
      if (req_size == SZ_HALF) acc_addr[0] = 1'b0;
      if (req_size == SZ_WORD) acc_addr[1:0] = 2'b00;
   end

`ifdef MAU_ALIGN_CHECK_EN
   logic misaligned, err_q;
   assign misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                       ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
   assign align_err  = (state == S_DONE) && err_q;

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else if (state == S_IDLE && req) err_q <= misaligned;
   end
`else
   assign align_err = 1'b0;
`endif

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: begin
            if (req) begin
               state_d = (MemCtrl && req_size == SZ_WORD) ? S_WR : S_RD;
`ifdef MAU_ALIGN_CHECK_EN
               if (misaligned) state_d = S_DONE;
`endif
            end
         end
         S_RD:    state_d = S_WAIT;
         S_WAIT:  if (cnt <= 4'd1) state_d = is_wr ? S_WR : S_DONE;
         S_WR:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         is_wr   <= 1'b0;
         size_q  <= SZ_WORD;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
         cnt     <= 4'd0;
         rdata   <= 32'h0;
      end else begin
         state <= state_d;
         if (state == S_IDLE && req) begin
            is_wr   <= MemCtrl;
            size_q  <= req_size;
            addr_q  <= acc_addr;
            wdata_q <= wdata;
         end
         if (state == S_RD) cnt <= 4'(MEM_LAT);
         if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) begin
               word_q <= mem_rdata;
               if (!is_wr) rdata <= lane_ext;
            end
         end
      end
   end

   // Extract sees the memory bus directly in WAIT; merge works on the captured word in WR.
   assign lane_word = (state == S_WAIT) ? mem_rdata : word_q;

   lane_mux u_lane_mux (
      .size   (size_q),
      .off    (addr_q[1:0]),
      .word   (lane_word),
      .wdata  (wdata_q),
      .ext    (lane_ext),
      .merged (lane_merged)
   );

   assign done      = (state == S_DONE);
   assign busy      = (state == S_RD) || (state == S_WAIT) || (state == S_WR);
   assign mem_re    = (state == S_RD) && !reset;
   assign mem_we    = (state == S_WR) && !reset;
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = (state == S_WR) ? lane_merged : 32'h0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side responder for the multicycle controller's load/store requests.
- Accepts one request per transaction: read or write, address, store data, and size (word/half/byte).
- Drives a fixed-latency, word-wide, big-endian memory.
- Sub-word stores use read-modify-write. Loads return the zero-extended selected field.
- Signals completion with a one-cycle done pulse so the controller can hold its state until then.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_LAT, 2, cycles from mem_re to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only while busy=0.
- MemCtrl  in  1  1=write (store), 0=read (load).
- LSCtrl  in  2  load size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- SSCtrl  in  2  store size: same encoding as LSCtrl.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified for half/byte.
- rdata  out  32  load result, zero-extended; held until next load completes.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after accept until done.
- align_err  out  1  pulses with done on a misaligned access (feature enabled only).
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_re  out  1  one-cycle read strobe.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_re.

Behaviour:
- Reset: state=IDLE; rdata=0; done, busy, align_err, mem_re, mem_we all 0; mem_addr=0; mem_wdata=0; latency counter=0.
- Reset mid-transaction aborts immediately. No write is issued after reset is asserted.
- Accept: in IDLE with req=1, latch MemCtrl, size, addr, wdata. A req while busy is ignored.
- Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24, =3 selects bits 7:0. A half at addr[1]=0 selects bits 31:16.
- States:
  - IDLE -> RD on a load, or on a half/byte store.
  - IDLE -> WR on a word store.
  - IDLE -> DONE on misalignment (feature enabled); no memory strobe is issued.
  - RD: assert mem_re for 1 cycle, load counter with MEM_LAT, -> WAIT.
  - WAIT: decrement the counter. When it reaches 0, capture mem_rdata. A load goes to DONE (rdata updated in that cycle); a store goes to WR.
  - WR: mem_we=1 for 1 cycle with mem_wdata = merged word (captured word with the selected lanes replaced by wdata's low bits; word store uses wdata directly) -> DONE.
  - DONE: done=1 for 1 cycle, busy=0 in that cycle, -> IDLE. A req in the DONE cycle is ignored; next accept is in IDLE.
- Latency, counted from the req cycle to the done cycle: load = MEM_LAT+2; sub-word store = MEM_LAT+3; word store = 2; misaligned = 1.
- busy is 1 in RD, WAIT and WR; 0 in IDLE and DONE.
- mem_addr = {addr[ADDR_W-1:2], 2'b00}, held stable from RD/WR through the end of WAIT/WR.
- Reserved size 11 behaves exactly as word.

Optional Feature:
- MAU_ALIGN_CHECK_EN defined:
  - A half with addr[0]=1, or a word with addr[1:0]!=0, is misaligned.
  - No memory access occurs. done and align_err pulse together. rdata and memory are unchanged.
- Not defined:
  - align_err is tied 0.
  - The low address bits are forced to alignment: addr[0] is cleared for half, addr[1:0] for word. The access then proceeds normally.

Decomposition:
- Shared package (mem_pkg) holds:
  - Size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - State enum: IDLE, RD, WAIT, WR, DONE.
  - MEM_LAT default.
- One natural sub-module, lane_mux: combinational extract (load) and merge (store) given size, addr[1:0], word and wdata. It is shared by the RD/WAIT capture and WR paths and unit-tested alone.

Test Plan:
- Memory word 0x11223344 at 0x100. Load byte at 0x102 -> rdata=0x00000033; done at req+MEM_LAT+2 (4 cycles with default).
- Store half 0xBEEF at 0x100 over 0x11223344 -> one mem_re, then one mem_we with mem_wdata=0xBEEF3344; readback word =0xBEEF3344.
- Store word 0xCAFEF00D at 0x104 -> no mem_re, mem_we at req+1, done at req+2.
- With MAU_ALIGN_CHECK_EN: load word at 0x102 -> done and align_err at req+1, no mem strobes, rdata unchanged. Without it: same access reads word 0x100.
- Second req pulsed during WAIT -> ignored (exactly one done). Reset asserted in WAIT of a byte store -> no mem_we ever, all outputs 0 the next cycle.
- MEM_LAT=1 and MEM_LAT=15 builds -> load latency 3 and 17 respectively; data correct.
